// File: rtl/event_capture_8.sv
// Event capture ahead of the 8-to-3 encoder: synchronizes eight request lines,
// queues their rising edges and hands them out one-hot, round-robin, over valid/ready.
module event_capture_8 #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in,
  output logic [7:0] d,
  output logic       valid,
  input  logic       ready,
  output logic [7:0] pending,
  output logic       overflow
);

  logic [7:0] sync_q [SYNC_STAGES];
  logic [7:0] sync_d [SYNC_STAGES];
  logic [7:0] prev_q, prev_d;
  logic [7:0] pending_q, pending_d;
  logic [7:0] d_q, d_d;
  logic       valid_q, valid_d;
  logic       overflow_q, overflow_d;
  logic [2:0] ptr_q, ptr_d;

  logic [7:0] sync_out;
  logic [7:0] rise;
  logic       slot_free;
  logic       load;
  logic       sel_found;
  logic [2:0] sel_idx;
  logic [2:0] idx;
  logic [7:0] sel_onehot;
  logic [7:0] clr;

  always_comb begin
    sync_d[0] = in;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~prev_q;
  assign prev_d   = sync_out;

  // First pending line at or above ptr, wrapping; only registered pending is considered.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = ptr_q;
    idx       = '0;
    for (int j = 0; j < 8; j++) begin
      idx = ptr_q + 3'(j);
      if (!sel_found && pending_q[idx]) begin
        sel_found = 1'b1;
        sel_idx   = idx;
      end
    end
  end

  assign sel_onehot = 8'h01 << sel_idx;
  assign slot_free  = ~valid_q | ready;
  assign load       = slot_free & sel_found;
  assign clr        = load ? sel_onehot : 8'h00;

  always_comb begin
    d_d        = d_q;
    valid_d    = valid_q;
    ptr_d      = ptr_q;
    // Set wins over clear; a fresh edge on an already-pending line is a lost event,
    // unless that same line is being handed out this cycle.
    pending_d  = (pending_q & ~clr) | rise;
    overflow_d = overflow_q | (|(rise & pending_q & ~clr));
    if (slot_free) begin
      if (load) begin
        d_d     = sel_onehot;
        valid_d = 1'b1;
        ptr_d   = sel_idx + 3'd1;
      end else begin
        d_d     = 8'h00;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      prev_q     <= '0;
      pending_q  <= '0;
      d_q        <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      ptr_q      <= '0;
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
      prev_q     <= prev_d;
      pending_q  <= pending_d;
      d_q        <= d_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      ptr_q      <= ptr_d;
    end
  end

  assign d        = d_q;
  assign valid    = valid_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_event_capture_8.sv
// Scoreboard bench for event_capture_8: directed stimulus pushes expected events,
// a negedge monitor pops them on every accepted handshake.
module tb_event_capture_8;

  logic       clk = 1'b0;
  logic       rst;
  logic       ready;
  logic [7:0] in;
  logic [7:0] d;
  logic [7:0] pending;
  logic       valid;
  logic       overflow;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  event_capture_8 #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .in(in), .d(d), .valid(valid),
    .ready(ready), .pending(pending), .overflow(overflow)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end else begin
      $display("ok   %s: %02h", name, act);
    end
  endtask

  // Monitor: each cycle with valid & ready is one accepted event.
  always @(negedge clk) begin
    if (!rst) begin
      if ((valid != (|d)) || !$onehot0(d)) begin
        chk("invariant_d", d, valid ? 8'h01 : 8'h00);
      end
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", d, 8'h00);
        end else begin
          chk("event", d, exp_q.pop_front());
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1; exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    rst = 1'b1; ready = 1'b0; in = 8'h00;
    cycles(3);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_d", d, 8'h00);
    chk("reset_valid", 8'(valid), 8'h00);
    chk("reset_pending", pending, 8'h00);
    chk("reset_overflow", 8'(overflow), 8'h00);

    // Single event with exact latency
    ready = 1'b1;
    exp_q.push_back(8'h20);
    @(posedge clk); #1 in = 8'h20;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("single_pending", pending, 8'h20);
    chk("single_not_yet_valid", 8'(valid), 8'h00);
    @(negedge clk);
    chk("single_d", d, 8'h20);
    chk("single_valid", 8'(valid), 8'h01);
    @(negedge clk);
    chk("single_after_valid", 8'(valid), 8'h00);
    chk("single_after_d", d, 8'h00);

    // Wrap: ptr is 6 after serving line 5
    @(posedge clk); #1 in = 8'h00;
    cycles(4);
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h02);
    in = 8'h82;
    cycles(8);
    chk("wrap_drained", pending, 8'h00);
    in = 8'h00;

    // Round robin over all lines
    do_reset();
    ready = 1'b0;
    in = 8'hFF;
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      if (pending == 8'hFF) hit = 1'b1;
    end
    chk("rr_pending_full", pending, 8'hFF);
    for (int k = 0; k < 8; k++) exp_q.push_back(8'(1 << k));
    @(posedge clk); #1 ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_seq", d, 8'(1 << k));
    end
    @(negedge clk);
    chk("rr_end_valid", 8'(valid), 8'h00);
    #1 in = 8'h00;

    // Stall and overflow
    cycles(4);
    ready = 1'b0;
    exp_q.push_back(8'h04);
    in = 8'h04;
    cycles(5);
    chk("stall_d", d, 8'h04);
    in = 8'h0C; cycles(2);
    in = 8'h04; cycles(4);
    chk("stall_pend3", pending, 8'h08);
    chk("stall_no_overflow", 8'(overflow), 8'h00);
    in = 8'h0C; cycles(2);
    in = 8'h04; cycles(4);
    chk("stall_overflow", 8'(overflow), 8'h01);
    chk("stall_d_held", d, 8'h04);
    chk("stall_pend3_held", pending, 8'h08);
    exp_q.push_back(8'h08);
    ready = 1'b1;
    cycles(4);
    chk("overflow_sticky", 8'(overflow), 8'h01);
    chk("stall_drained", 8'(valid), 8'h00);
    in = 8'h00;
    do_reset();
    @(negedge clk);
    chk("overflow_cleared", 8'(overflow), 8'h00);

    // Set-wins collision on line 4
    #1 ready = 1'b0;
    cycles(3);
    exp_q.push_back(8'h01);
    in = 8'h01;
    cycles(5);
    in = 8'h11; cycles(2);
    in = 8'h01; cycles(4);
    chk("sw_pend4", pending, 8'h10);
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h10);
    in = 8'h11;
    @(posedge clk);
    @(posedge clk); #1 ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("sw_d", d, 8'h10);
    chk("sw_pend4_kept", pending, 8'h10);
    chk("sw_no_overflow", 8'(overflow), 8'h00);
    cycles(4);
    chk("sw_drained", pending, 8'h00);
    in = 8'h00; ready = 1'b0;

    // Mid-operation reset
    cycles(4);
    in = 8'h08;
    cycles(5);
    chk("mr_d", d, 8'h08);
    in = 8'h38;
    hit = 1'b0;
    for (int c = 0; c < 10 && !hit; c++) begin
      @(negedge clk);
      if (pending == 8'h30) hit = 1'b1;
    end
    chk("mr_pending", pending, 8'h30);
    @(posedge clk); #1 rst = 1'b1; exp_q.delete(); in = 8'h08;
    @(posedge clk); #1;
    chk("mr_rst_d", d, 8'h00);
    chk("mr_rst_valid", 8'(valid), 8'h00);
    chk("mr_rst_pending", pending, 8'h00);
    rst = 1'b0;
    exp_q.push_back(8'h08);
    ready = 1'b1;
    cycles(8);
    chk("mr_one_event", 8'(valid), 8'h00);
    in = 8'h00;
    cycles(4);
    chk("queue_empty", 8'(exp_q.size()), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
